// File: rtl/johnson_dec_chk.sv
// johnson_dec_chk: Johnson code stream decoder with legality/step checking and lock tracking
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous reset, active-low
//   code_in   in   WIDTH  Johnson code sample
//   code_vld  in   1      code_in valid this cycle
//   err_clr   in   1      synchronous clear of err_cnt
//   idx       out  IDX_W  decoded index 0..2*WIDTH-1
//   idx_vld   out  1      pulse per accepted legal code
//   locked    out  1      sequence locked
//   err_pulse out  1      pulse on detected error while locked
//   err_cnt   out  ERR_W  saturating error count
// Optional feature: define JDEC_ERR_CNT_EN to implement err_cnt/err_clr;
// otherwise err_cnt is tied to zero and err_clr is ignored.
module johnson_dec_chk #(
  parameter int WIDTH = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W = 8,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_vld,
  input  logic             err_clr,
  output logic [IDX_W-1:0] idx,
  output logic             idx_vld,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int SEQ_LEN = 2 * WIDTH;
  localparam int CNT_W = LOCK_CNT > 1 ? $clog2(LOCK_CNT + 1) : 1;
  typedef enum logic [1:0] {HUNT, LOCKING, LOCKED} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] prev, prev_d, idx_d, dec, prev_inc;
  logic [WIDTH-2:0] diff;
  logic [IDX_W:0] ones;
  logic legal, is_step, is_hold, vld_d, err_d;
  // A valid Johnson code has at most one 0/1 boundary between neighbouring bits
  assign diff = code_in[WIDTH-1:1] ^ code_in[WIDTH-2:0];
  assign legal = (diff & (diff - (WIDTH-1)'(1))) == '0;
  // Rising half of the sequence counts ones; falling half counts back from 2*WIDTH
  assign ones = (IDX_W+1)'($countones(code_in));
  assign dec = code_in[WIDTH-1] ? IDX_W'(SEQ_LEN - int'(ones)) : IDX_W'(ones);
  assign prev_inc = prev == IDX_W'(SEQ_LEN - 1) ? '0 : prev + IDX_W'(1);
  assign is_step = dec == prev_inc;
  assign is_hold = dec == prev;
  assign locked = state == LOCKED;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    prev_d = prev;
    idx_d = idx;
    vld_d = 1'b0;
    err_d = 1'b0;
    if (code_vld) begin
      if (legal) begin
        idx_d = dec;
        prev_d = dec;
        vld_d = 1'b1;
      end
      case (state)
        HUNT: begin
          state_d = legal ? LOCKING : HUNT;
          cnt_d = legal ? '0 : cnt;
        end
        LOCKING: begin
          if (!legal) state_d = HUNT;
          else if (is_step) begin
            cnt_d = cnt + CNT_W'(1);
            state_d = cnt == CNT_W'(LOCK_CNT - 1) ? LOCKED : LOCKING;
          end else if (!is_hold) cnt_d = '0;
        end
        LOCKED: begin
          err_d = !legal || !(is_step || is_hold);
          state_d = err_d ? HUNT : LOCKED;
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
      cnt <= '0;
      prev <= '0;
      idx <= '0;
      idx_vld <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      prev <= prev_d;
      idx <= idx_d;
      idx_vld <= vld_d;
      err_pulse <= err_d;
    end
  end
`ifdef JDEC_ERR_CNT_EN
  // A clear coinciding with an error leaves exactly that one error counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt <= '0;
    else if (err_clr) err_cnt <= ERR_W'(err_d);
    else if (err_d && !(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
  end
`else
  logic unused_clr;
  assign unused_clr = err_clr;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_johnson_dec_chk.sv
// tb_johnson_dec_chk: randomized and directed check of johnson_dec_chk against a table-driven model
module tb_johnson_dec_chk;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] code_in = '0;
  logic code_vld = 1'b0;
  logic err_clr = 1'b0;
  logic [2:0] idx;
  logic idx_vld, locked, err_pulse;
  logic [7:0] err_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] seq [8];
  int m_state, m_cnt, m_prev, m_idx, m_vld, m_err, m_errs;
  johnson_dec_chk #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_vld(code_vld), .err_clr(err_clr),
    .idx(idx), .idx_vld(idx_vld), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, int obs, int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask
  function automatic int find(logic [3:0] c);
    for (int i = 0; i < 8; i++) if (seq[i] == c) return i;
    return -1;
  endfunction
  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_prev = 0; m_idx = 0; m_vld = 0; m_err = 0; m_errs = 0;
  endtask
  // states: 0 hunting, 1 locking, 2 locked
  task automatic model(logic [3:0] c, logic v, logic e);
    int k, d;
    m_vld = 0;
    m_err = 0;
    if (v) begin
      k = find(c);
      if (k < 0) begin
        if (m_state == 2) m_err = 1;
        m_state = 0;
      end else begin
        d = (k - m_prev + 8) % 8;
        m_vld = 1;
        m_idx = k;
        if (m_state == 0) begin
          m_state = 1;
          m_cnt = 0;
        end else if (m_state == 1) begin
          if (d == 1) begin
            m_cnt++;
            if (m_cnt >= 2) m_state = 2;
          end else if (d != 0) m_cnt = 0;
        end else if (d > 1) begin
          m_err = 1;
          m_state = 0;
        end
        m_prev = k;
      end
    end
`ifdef JDEC_ERR_CNT_EN
    if (e) m_errs = m_err;
    else if (m_err != 0 && m_errs < 255) m_errs++;
`else
    m_errs = 0;
`endif
  endtask
  task automatic compare_all();
    check("idx", int'(idx), m_idx);
    check("idx_vld", int'(idx_vld), m_vld);
    check("locked", int'(locked), int'(m_state == 2));
    check("err_pulse", int'(err_pulse), m_err);
    check("err_cnt", int'(err_cnt), m_errs);
  endtask
  task automatic cyc(logic [3:0] c, logic v, logic e);
    code_in = c;
    code_vld = v;
    err_clr = e;
    @(posedge clk);
    model(c, v, e);
    #1;
    compare_all();
    code_vld = 1'b0;
    err_clr = 1'b0;
  endtask
  task automatic feed(int k);
    cyc(seq[k % 8], 1'b1, 1'b0);
  endtask
  initial begin
    int pos, r, c;
    seq[0] = 4'b0000;
    for (int i = 0; i < 7; i++) seq[i+1] = {seq[i][2:0], ~seq[i][3]};
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk) rst = 1'b1;
    cyc(4'b0000, 1'b0, 1'b0);
    foreach (seq[i]) feed(i);
    feed(0);
    feed(1); feed(2); feed(4);
    feed(5); feed(6); feed(7); feed(0);
    cyc(4'b0101, 1'b1, 1'b0);
    repeat (3) cyc(4'b0011, 1'b1, 1'b0);
    feed(4); feed(5);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    @(negedge clk) rst = 1'b1;
    cyc(4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      feed(i); feed(i + 1); feed(i + 2); feed(i + 4);
    end
    feed(0); feed(1); feed(2);
    cyc(seq[5], 1'b1, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    pos = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        pos = (pos + 1) % 8;
        cyc(seq[pos], 1'b1, $urandom_range(0, 99) < 3);
      end else if (r < 70) cyc(seq[pos], 1'b1, 1'b0);
      else if (r < 80) begin
        pos = (pos + $urandom_range(2, 7)) % 8;
        cyc(seq[pos], 1'b1, $urandom_range(0, 99) < 3);
      end else if (r < 90) begin
        c = $urandom_range(0, 15);
        while (find(4'(c)) >= 0) c = $urandom_range(0, 15);
        cyc(4'(c), 1'b1, 1'b0);
      end else cyc(4'($urandom_range(0, 15)), 1'b0, $urandom_range(0, 99) < 10);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
